// File: rtl/iccm_loader.sv
// Boot-time ICCM writer: assembles a little-endian byte stream into 32-bit words,
// writes them sequentially and releases core reset once the image is loaded.
// Optional trailing checksum check enabled by defining ICCM_LOADER_CSUM_EN.
module iccm_loader #(
   parameter int unsigned ICCM_DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_WORD_ADDR   = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,
   output logic        iccm_wr_en,
   output logic [31:0] iccm_wr_addr,
   output logic [31:0] iccm_wr_data,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        load_err
);

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
`ifdef ICCM_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic [31:0] len;
   logic [31:0] word_cnt;
`ifdef ICCM_LOADER_CSUM_EN
   logic [31:0] csum_s;
`endif

   logic        accept;
   logic        word_last;
   logic [31:0] full_word;

   // The word is complete on the fourth byte; its top lane comes straight off the bus.
   always_comb begin
      accept    = ld_valid & ld_ready;
      word_last = accept & (byte_cnt == 2'd3);
      full_word = {ld_data, word_buf};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_HDR;
         byte_cnt     <= 2'd0;
         word_buf     <= 24'd0;
         len          <= 32'd0;
         word_cnt     <= 32'd0;
         ld_ready     <= 1'b0;
         iccm_wr_en   <= 1'b0;
         iccm_wr_addr <= 32'd0;
         iccm_wr_data <= 32'd0;
         core_rst_n   <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
`ifdef ICCM_LOADER_CSUM_EN
         csum_s       <= 32'd0;
`endif
      end else begin
         iccm_wr_en <= 1'b0;
         // Ready tracks the state; transitions into a terminal state override it below.
         ld_ready   <= (state != S_DONE) && (state != S_ERR);

         if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    word_buf[7:0]   <= ld_data;
               2'd1:    word_buf[15:8]  <= ld_data;
               2'd2:    word_buf[23:16] <= ld_data;
               default: ;
            endcase
         end

         case (state)
            S_HDR: begin
               if (word_last) begin
                  if (full_word == 32'd0 || full_word > ICCM_DEPTH_WORDS) begin
                     state    <= S_ERR;
                     ld_ready <= 1'b0;
                  end else begin
                     len   <= full_word;
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (word_last) begin
                  iccm_wr_en   <= 1'b1;
                  iccm_wr_addr <= BASE_WORD_ADDR + word_cnt;
                  iccm_wr_data <= full_word;
                  word_cnt     <= word_cnt + 32'd1;
`ifdef ICCM_LOADER_CSUM_EN
                  csum_s       <= csum_s + full_word;
                  if (word_cnt == len - 32'd1)
                     state <= S_CSUM;
`else
                  if (word_cnt == len - 32'd1) begin
                     state    <= S_DONE;
                     ld_ready <= 1'b0;
                  end
`endif
               end
            end
`ifdef ICCM_LOADER_CSUM_EN
            S_CSUM: begin
               if (word_last) begin
                  state    <= (full_word == csum_s) ? S_DONE : S_ERR;
                  ld_ready <= 1'b0;
               end
            end
`endif
            S_DONE: begin
               load_done  <= 1'b1;
               core_rst_n <= 1'b1;
            end
            S_ERR: begin
               load_err <= 1'b1;
            end
            default: begin
               state    <= S_ERR;
               ld_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iccm_loader.sv
// Self-checking bench for iccm_loader: randomized byte streams and gaps checked
// against an image-level model of the expected ICCM writes and final outcome.
module tb_iccm_loader;
   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = 8'd0;
   logic        ld_ready, iccm_wr_en, core_rst_n, load_done, load_err;
   logic [31:0] iccm_wr_addr, iccm_wr_data;

   always #5 clk = ~clk;

   iccm_loader #(.ICCM_DEPTH_WORDS(DEPTH), .BASE_WORD_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .iccm_wr_en(iccm_wr_en), .iccm_wr_addr(iccm_wr_addr),
      .iccm_wr_data(iccm_wr_data), .core_rst_n(core_rst_n),
      .load_done(load_done), .load_err(load_err)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] words_q[$];
   logic [7:0]  img[$];
   bit          exp_ok;
   int          pulse_wide = 0;
   logic        prev_en = 1'b0;

   always @(negedge clk) begin
      if (iccm_wr_en) got_q.push_back({iccm_wr_addr, iccm_wr_data});
      if (iccm_wr_en && prev_en) pulse_wide++;
      prev_en = iccm_wr_en;
   end

   // Model: header N, N words at BASE+i, then (if enabled) the modular word sum.
   task automatic make_image(input bit bad_csum);
      logic [31:0] n, sum, c;
      n = words_q.size();
      sum = 0;
      img = {};
      exp_q = {};
      for (int b = 0; b < 4; b++) img.push_back(8'((n >> (8 * b)) & 32'hFF));
      foreach (words_q[i]) begin
         for (int b = 0; b < 4; b++) img.push_back(8'((words_q[i] >> (8 * b)) & 32'hFF));
         sum = sum + words_q[i];
         exp_q.push_back({BASE + 32'(i), words_q[i]});
      end
`ifdef ICCM_LOADER_CSUM_EN
      c = bad_csum ? sum + 32'd1 : sum;
      for (int b = 0; b < 4; b++) img.push_back(8'((c >> (8 * b)) & 32'hFF));
      exp_ok = !bad_csum;
`else
      c = 0;
      exp_ok = 1'b1;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ld_valid = 1'b0;
      repeat (2) @(negedge clk);
      got_q = {};
      pulse_wide = 0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // gap_mode 0: back to back, 1: short random gaps, 2: random gaps including 10-cycle holes.
   task automatic send_bytes(input int gap_mode, input int count);
      int lim, gap, t;
      lim = (count < 0) ? img.size() : count;
      for (int i = 0; i < lim; i++) begin
         gap = 0;
         if (gap_mode == 1) gap = $urandom_range(0, 2);
         if (gap_mode == 2) gap = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         ld_valid = 1'b1;
         ld_data  = img[i];
         t = 0;
         while (!ld_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout byte %0d: ld_ready stayed %b, required 1", i, ld_ready);
            ld_valid = 1'b0;
            return;
         end
         @(negedge clk);
         ld_valid = 1'b0;
      end
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(load_done || load_err) && t < 40) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ld_ready, iccm_wr_en, iccm_wr_addr, iccm_wr_data, core_rst_n, load_done, load_err} !== 69'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got rdy=%b en=%b addr=%h data=%h crst=%b done=%b err=%b, required all 0",
                  ld_ready, iccm_wr_en, iccm_wr_addr, iccm_wr_data, core_rst_n, load_done, load_err);
      end
      do_reset();
      n_cmp++;
      if (ld_ready !== 1'b1 || core_rst_n !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release rdy=%b crst=%b, required rdy=1 crst=0", ld_ready, core_rst_n);
      end
   endtask

   task automatic test_basic();
      words_q = {32'h0000_0013, 32'h0010_0093};
      make_image(1'b0);
      do_reset();
      send_bytes(0, -1);
`ifndef ICCM_LOADER_CSUM_EN
      n_cmp++;
      if (iccm_wr_en !== 1'b1 || {iccm_wr_addr, iccm_wr_data} !== {32'd1, 32'h0010_0093}) begin
         n_bad++;
         $display("FAIL basic_latency en=%b addr=%h data=%h, required en=1 addr=1 data=00100093",
                  iccm_wr_en, iccm_wr_addr, iccm_wr_data);
      end
`endif
      n_cmp++;
      if (load_done !== 1'b0 || core_rst_n !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_entry done=%b crst=%b, required 0 0", load_done, core_rst_n);
      end
      @(negedge clk);
      n_cmp++;
      if (load_done !== 1'b1 || core_rst_n !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_done done=%b crst=%b, required 1 1", load_done, core_rst_n);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL basic_wcount got %0d writes, required %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL basic_write%0d got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (load_err !== 1'b0 || ld_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_final err=%b rdy=%b, required 0 0", load_err, ld_ready);
      end
   endtask

   task automatic test_gaps();
      words_q = {32'h0000_0013, 32'h0010_0093};
      make_image(1'b0);
      do_reset();
      send_bytes(2, -1);
      wait_end();
      n_cmp++;
      if (got_q.size() != 2 || pulse_wide != 0) begin
         n_bad++;
         $display("FAIL gaps_pulses got %0d writes, %0d wide, required 2 and 0", got_q.size(), pulse_wide);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL gaps_write%0d got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (load_done !== 1'b1 || core_rst_n !== 1'b1) begin
         n_bad++;
         $display("FAIL gaps_done done=%b crst=%b, required 1 1", load_done, core_rst_n);
      end
   endtask

   task automatic test_bad_header();
      logic [31:0] hdrs[3];
      logic [31:0] h;
      hdrs[0] = 32'd0;
      hdrs[1] = DEPTH + 1;
      hdrs[2] = DEPTH;
      foreach (hdrs[k]) begin
         h = hdrs[k];
         img = {};
         for (int b = 0; b < 4; b++) img.push_back(8'((h >> (8 * b)) & 32'hFF));
         do_reset();
         send_bytes(1, -1);
         repeat (3) @(negedge clk);
         n_cmp++;
         if (k < 2) begin
            if (load_err !== 1'b1 || load_done !== 1'b0 || core_rst_n !== 1'b0 ||
                ld_ready !== 1'b0 || got_q.size() != 0) begin
               n_bad++;
               $display("FAIL bad_hdr N=%0d err=%b done=%b crst=%b rdy=%b writes=%0d, required 1 0 0 0 0",
                        h, load_err, load_done, core_rst_n, ld_ready, got_q.size());
            end
         end else begin
            if (load_err !== 1'b0 || ld_ready !== 1'b1 || got_q.size() != 0) begin
               n_bad++;
               $display("FAIL max_hdr N=%0d err=%b rdy=%b writes=%0d, required 0 1 0",
                        h, load_err, ld_ready, got_q.size());
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      words_q = {32'h0000_0013, 32'h0010_0093};
      make_image(1'b0);
      do_reset();
      send_bytes(1, 10);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 1) begin
         n_bad++;
         $display("FAIL midrst_before got %0d writes, required 1", got_q.size());
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (core_rst_n !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_async crst=%b rdy=%b done=%b, required 0 0 0", core_rst_n, ld_ready, load_done);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 1) begin
         n_bad++;
         $display("FAIL midrst_partial got %0d writes, required 1", got_q.size());
      end
      do_reset();
      send_bytes(1, -1);
      wait_end();
      n_cmp++;
      if (got_q.size() != exp_q.size() || load_done !== 1'b1 || core_rst_n !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_reload writes=%0d done=%b crst=%b, required %0d 1 1",
                  got_q.size(), load_done, core_rst_n, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL midrst_write%0d got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      bit bad;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 6);
         words_q = {};
         for (int i = 0; i < n; i++) words_q.push_back($urandom);
         bad = 1'b0;
`ifdef ICCM_LOADER_CSUM_EN
         bad = ($urandom_range(0, 2) == 0);
`endif
         make_image(bad);
         do_reset();
         send_bytes(1, -1);
         wait_end();
         n_cmp++;
         if (got_q.size() != exp_q.size() || pulse_wide != 0) begin
            n_bad++;
            $display("FAIL rand%0d_wcount got %0d writes (%0d wide), required %0d",
                     it, got_q.size(), pulse_wide, exp_q.size());
         end
         foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL rand%0d_write%0d got %h, required %h", it, i, got_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if (load_done !== exp_ok || load_err !== !exp_ok || core_rst_n !== exp_ok) begin
            n_bad++;
            $display("FAIL rand%0d_status done=%b err=%b crst=%b, required %b %b %b",
                     it, load_done, load_err, core_rst_n, exp_ok, !exp_ok, exp_ok);
         end
      end
   endtask

   task automatic test_trailing();
      int ready_seen = 0;
      words_q = {32'h0000_0013, 32'h0010_0093};
      make_image(1'b0);
      do_reset();
      send_bytes(0, -1);
      wait_end();
      for (int i = 0; i < 12; i++) begin
         ld_valid = 1'b1;
         ld_data  = 8'($urandom);
         @(negedge clk);
         if (ld_ready) ready_seen++;
      end
      ld_valid = 1'b0;
      n_cmp++;
      if (ready_seen != 0 || got_q.size() != 2 || load_done !== 1'b1 || load_err !== 1'b0) begin
         n_bad++;
         $display("FAIL trailing ready_cycles=%0d writes=%0d done=%b err=%b, required 0 2 1 0",
                  ready_seen, got_q.size(), load_done, load_err);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (core_rst_n !== 1'b0 || load_done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_async_rst crst=%b done=%b, required 0 0", core_rst_n, load_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef ICCM_LOADER_CSUM_EN
   task automatic test_csum_bad();
      words_q = {32'h0000_0013, 32'h0010_0093};
      make_image(1'b1);
      do_reset();
      send_bytes(1, -1);
      wait_end();
      n_cmp++;
      if (got_q.size() != 2 || load_err !== 1'b1 || load_done !== 1'b0 || core_rst_n !== 1'b0) begin
         n_bad++;
         $display("FAIL csum_bad writes=%0d err=%b done=%b crst=%b, required 2 1 0 0",
                  got_q.size(), load_err, load_done, core_rst_n);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_bad_header();
      test_mid_reset();
      test_random();
      test_trailing();
`ifdef ICCM_LOADER_CSUM_EN
      test_csum_bad();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
- Boot-time ICCM writer: the write-side initiator for the instruction memory that the core only ever reads.
- Accepts a byte stream over a valid/ready handshake (from a debug UART or testbench) and assembles little-endian 32-bit words.
- Writes those words sequentially into ICCM at word addresses.
- Holds the core in reset until the image is fully and correctly loaded.

Parameters:
- ICCM_DEPTH_WORDS, 4096, ICCM capacity in 32-bit words; upper bound on image length.
- BASE_WORD_ADDR, 0, first ICCM word address written.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- ld_valid  input  1  byte-stream valid
- ld_data  input  8  byte-stream data
- ld_ready  output  1  loader accepts a byte this cycle
- iccm_wr_en  output  1  one-cycle ICCM write strobe
- iccm_wr_addr  output  32  ICCM word address (not byte address)
- iccm_wr_data  output  32  assembled instruction word
- core_rst_n  output  1  registered core reset release, active-low
- load_done  output  1  sticky; image loaded OK
- load_err  output  1  sticky; header or checksum error

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` asynchronous, active-low.
- Reset values: all outputs 0, including core_rst_n=0 (core held in reset). State=HDR, byte_cnt=0, word_cnt=0.
- Byte acceptance: a byte is accepted when ld_valid && ld_ready at a rising edge. ld_ready=1 in HDR, DATA and CSUM; ld_ready=0 in DONE and ERR.
- Byte assembly: byte_cnt (2 bits) selects the lane. First byte goes to [7:0], fourth to [31:24]. byte_cnt wraps 3->0 when a word completes.
- HDR state:
  - Four bytes form length N (little-endian).
  - On the fourth byte: if N==0 or N>ICCM_DEPTH_WORDS -> ERR; else latch N -> DATA.
- DATA state:
  - On acceptance of the fourth byte of a word, the next cycle drives iccm_wr_en=1 for exactly one cycle, with iccm_wr_addr=BASE_WORD_ADDR+word_cnt and iccm_wr_data=assembled word. Write latency is 1 cycle after the last byte.
  - word_cnt then increments.
  - After write N is issued: go to CSUM if the checksum feature is enabled, otherwise DONE.
  - The next byte may be accepted in the same cycle the write strobe is high; no stall is needed because ICCM writes are single-cycle.
- DONE state (terminal): load_done=1 and core_rst_n=1, both asserted on the cycle after entry. Further bytes are ignored (ld_ready=0).
- ERR state (terminal): load_err=1, core_rst_n stays 0, no further ICCM writes.
- Exit from DONE/ERR: only via rst_n.
- Mid-load reset: rst_n low during a load aborts it immediately. A partial word is discarded, core_rst_n drops to 0 asynchronously, and the sequence restarts at HDR on release. Already-written ICCM words are not cleared.
- Arithmetic: word_cnt is 32-bit. The address sum is 32-bit and wraps modulo 2^32; the header check guarantees no overflow past depth.
- Idle input: ld_valid low for any number of cycles stalls without state change. No timeout.

Optional Feature:
- Macro: ICCM_LOADER_CSUM_EN.
- Defined:
  - After the N data words the stream carries a 4-byte little-endian checksum C.
  - The loader keeps a running 32-bit modular sum S of all data words; the S register is reset to 0.
  - If C==S -> DONE, else -> ERR.
  - The ICCM writes have already happened; only the core reset release is gated.
- Undefined: no CSUM state and no S register; the stream ends after the data words and the loader enters DONE directly.

Test Plan:
- Basic load: header 02 00 00 00, data 13 00 00 00, 93 00 10 00, feature off -> two writes: addr 0 data 0x00000013, addr 1 data 0x00100093. load_done=1 and core_rst_n=1 one cycle after entering DONE.
- Backpressure/gaps: same image with ld_valid toggled randomly, including 10-cycle gaps -> identical writes. iccm_wr_en pulses are exactly 1 cycle and exactly 2 in number.
- Bad header: N=0, then separately N=4097 at default depth -> ERR, load_err=1, no iccm_wr_en, core_rst_n stays 0, ld_ready=0.
- Mid-load reset: assert rst_n low after 6 data bytes -> core_rst_n=0 immediately, no write of the partial word. Reload of the full image after release succeeds.
- Checksum (ICCM_LOADER_CSUM_EN): N=2, words 0x00000013 and 0x00100093, C=0x001000A6 -> DONE. With C=0x001000A7 -> writes still occur, load_err=1, core_rst_n=0.
- Trailing bytes: extra bytes driven with ld_valid after DONE -> ld_ready=0, no further writes, state unchanged.
